puf2usrp_pkt: RTL and testbench

- Parametrised successor to the single-channel PUF-to-USRP I/Q adapter.
- Accepts wide beats of NCHAN complex samples (I in upper half, Q in lower half per channel) from a source that may present sparse valids.
- Buffers beats in a FIFO, serialises channels, converts sample width with rounding/saturation, and frames the output AXI-stream into packets of programmable length with tlast.
- Sits between the PUF front-end and the USRP radio/CHDR framer.

---
 rtl/puf2usrp_pkt_if.sv | 25 ++
 rtl/puf2usrp_pkt.sv | 166 ++++++++++++++++
 tb/tb_puf2usrp_pkt.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/puf2usrp_pkt_if.sv
// rtl/puf2usrp_pkt_if.sv - input beat stream and output sample stream of the PUF-to-USRP adapter
interface puf2usrp_pkt_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int NCHAN     = 2
);
  logic [NCHAN*2*IN_WIDTH-1:0] in_tdata;
  logic                        in_tvalid;
  logic                        in_tready;
  logic                        in_tlast;
  logic [2*OUT_WIDTH-1:0]      out_tdata;
  logic                        out_tvalid;
  logic                        out_tready;
  logic                        out_tlast;

  modport slave (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport master (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/puf2usrp_pkt.sv
// rtl/puf2usrp_pkt.sv - buffers multi-channel I/Q beats, serialises channels, converts width, frames packets
module puf2usrp_pkt #(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 16,
  parameter int NCHAN        = 2,
  parameter int FIFO_DEPTH   = 64,
  parameter int PKT_LEN_W    = 12,
  parameter bit BACKPRESSURE = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PKT_LEN_W-1:0]          cfg_pkt_len,
  puf2usrp_pkt_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);
  localparam int BW = NCHAN * 2 * IN_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int WW = IN_WIDTH + OUT_WIDTH + 2;
  localparam int SH = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH - OUT_WIDTH : 0;
  localparam int SL = (OUT_WIDTH > IN_WIDTH) ? OUT_WIDTH - IN_WIDTH : 0;
  localparam logic signed [WW-1:0] ONE  = WW'(1);
  localparam logic signed [WW-1:0] MAXV = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [WW-1:0] MINV = -(ONE <<< (OUT_WIDTH - 1));
  localparam logic signed [WW-1:0] RND  = (ONE <<< SH) >>> 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  logic [1:0]           rsync_q;
  logic                 run;
  logic [BW:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          level_q, level_d;
  logic                 full, empty, push, pop, drop;
  state_t               state_q, state_d;
  logic [BW-1:0]        hold_q, hold_d;
  logic                 hold_last_q, hold_last_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [PKT_LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cfg_len, cur_len;
  logic                 ovf_q;
  logic [15:0]          drop_q;
  logic                 last_ch, tlast, fire;
  logic [2*IN_WIDTH-1:0] cur;

  // Rounds half-up then clamps when narrowing; widening just left-aligns.
  function automatic logic [OUT_WIDTH-1:0] conv(input logic [IN_WIDTH-1:0] x);
    logic signed [WW-1:0] t;
    t = {{(WW-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    if (OUT_WIDTH >= IN_WIDTH) begin
      t = t <<< SL;
    end else begin
      t = (t + RND) >>> SH;
      if (t > MAXV) t = MAXV;
      else if (t < MINV) t = MINV;
    end
    return t[OUT_WIDTH-1:0];
  endfunction

  // Reset asserts immediately but releases the input side two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsync_q <= '0;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end
  assign run = rsync_q[1];

  assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign bus.in_tready = BACKPRESSURE ? (run && !full) : run;
  assign push  = bus.in_tvalid && bus.in_tready && !full;
  assign drop  = bus.in_tvalid && bus.in_tready && full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {bus.in_tlast, bus.in_tdata};
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign cur     = hold_q[ch_q*2*IN_WIDTH +: 2*IN_WIDTH];
  assign last_ch = (ch_q == CW'(NCHAN - 1));
  assign cfg_len = (cfg_pkt_len == '0) ? PKT_LEN_W'(1) : cfg_pkt_len;
  assign cur_len = (cnt_q == '0) ? cfg_len : len_q;
  assign tlast   = (state_q == S_SEND) &&
                   ((cnt_q == cur_len - 1'b1) || (last_ch && hold_last_q));
  assign fire    = (state_q == S_SEND) && bus.out_tready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    ch_d        = ch_q;
    pop         = 1'b0;
    cnt_d       = cnt_q;
    len_d       = len_q;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_LOAD;
      S_LOAD: begin
        pop                   = 1'b1;
        {hold_last_d, hold_d} = mem[rd_q];
        ch_d                  = '0;
        state_d               = S_SEND;
      end
      S_SEND: if (bus.out_tready) begin
        if (last_ch) begin
          ch_d    = '0;
          state_d = empty ? S_IDLE : S_LOAD;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fire) begin
      if (cnt_q == '0) len_d = cfg_len;
      cnt_d = tlast ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

  assign bus.out_tvalid = (state_q == S_SEND);
  assign bus.out_tlast  = tlast;
  assign bus.out_tdata  = {conv(cur[2*IN_WIDTH-1:IN_WIDTH]), conv(cur[IN_WIDTH-1:0])};
  assign fifo_level     = level_q;
  assign overflow       = ovf_q;
  assign drop_count     = drop_q;
endmodule

// File: tb/tb_puf2usrp_pkt.sv
// tb/tb_puf2usrp_pkt.sv - scoreboard bench: 16->16 backpressure instance and 16->12 drop-mode instance
module tb_puf2usrp_pkt;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] cfg_a = 12'd4;
  logic [11:0] cfg_b = 12'd5;
  logic [2:0]  level_a, level_b;
  logic        ovf_a, ovf_b;
  logic [15:0] drop_a, drop_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_v = 0;
  int acc_cyc = 0;
  bit lat_arm = 1'b0;
  int rdy_a = 1;
  int rdy_b = 1;
  int cnt_m [2];
  int len_m [2];
  logic [32:0] exp_a [$];
  logic [32:0] exp_b [$];
  bit          stall_a = 1'b0, stall_b = 1'b0;
  logic [32:0] hold_a;
  logic [24:0] hold_b;

  puf2usrp_pkt_if #(.IN_WIDTH(16), .OUT_WIDTH(16), .NCHAN(2)) ifa ();
  puf2usrp_pkt_if #(.IN_WIDTH(16), .OUT_WIDTH(12), .NCHAN(2)) ifb ();

  puf2usrp_pkt #(.IN_WIDTH(16), .OUT_WIDTH(16), .NCHAN(2), .FIFO_DEPTH(4),
                 .PKT_LEN_W(12), .BACKPRESSURE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cfg_pkt_len(cfg_a), .bus(ifa.slave),
    .fifo_level(level_a), .overflow(ovf_a), .drop_count(drop_a));

  puf2usrp_pkt #(.IN_WIDTH(16), .OUT_WIDTH(12), .NCHAN(2), .FIFO_DEPTH(4),
                 .PKT_LEN_W(12), .BACKPRESSURE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .cfg_pkt_len(cfg_b), .bus(ifb.slave),
    .fifo_level(level_b), .overflow(ovf_b), .drop_count(drop_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    ifa.out_tready = (rdy_a == 2) ? ($urandom_range(0, 3) != 0) : (rdy_a == 1);
    ifb.out_tready = (rdy_b == 2) ? ($urandom_range(0, 3) != 0) : (rdy_b == 1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic int conv(input logic [15:0] x, input int ow);
    int v, r;
    v = int'($signed(x));
    if (ow >= 16) begin
      r = v * (1 << (ow - 16));
    end else begin
      r = (v + (1 << (15 - ow))) >>> (16 - ow);
      if (r > (1 << (ow - 1)) - 1) r = (1 << (ow - 1)) - 1;
      if (r < -(1 << (ow - 1)))    r = -(1 << (ow - 1));
    end
    return r & ((1 << ow) - 1);
  endfunction

  task automatic model(input int sel, input logic [63:0] d, input logic l);
    int ow, cfgv;
    longint pk;
    bit last;
    ow   = (sel == 0) ? 16 : 12;
    cfgv = (sel == 0) ? int'(cfg_a) : int'(cfg_b);
    for (int ch = 0; ch < 2; ch++) begin
      if (cnt_m[sel] == 0) len_m[sel] = (cfgv == 0) ? 1 : cfgv;
      last = (cnt_m[sel] == len_m[sel] - 1) || (ch == 1 && l);
      cnt_m[sel] = last ? 0 : cnt_m[sel] + 1;
      pk = (longint'(conv(d[ch*32+16 +: 16], ow)) << ow) | longint'(conv(d[ch*32 +: 16], ow));
      if (sel == 0) exp_a.push_back({last, pk[31:0]});
      else          exp_b.push_back({last, pk[31:0]});
    end
  endtask

  task automatic send(input int sel, input logic [63:0] d, input logic l, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    if (sel == 0) begin
      ifa.in_tdata = d; ifa.in_tlast = l; ifa.in_tvalid = 1'b1;
      while (!ifa.in_tready && n < 500) begin @(negedge clk); n++; end
    end else begin
      ifb.in_tdata = d; ifb.in_tlast = l; ifb.in_tvalid = 1'b1;
      while (!ifb.in_tready && n < 500) begin @(negedge clk); n++; end
    end
    chk("accept_wait", 64'(n < 500), 64'd1);
    if (keep) model(sel, d, l);
    acc_cyc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ifa.in_tvalid = 1'b0;
    ifb.in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    chk("drain", 64'(exp_a.size() + exp_b.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon_a
    logic [32:0] e;
    if (!reset) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) chk("a_hold", {ifa.out_tvalid, ifa.out_tlast, ifa.out_tdata}, {1'b1, hold_a});
      if (lat_arm && ifa.out_tvalid) begin first_v = cyc; lat_arm = 1'b0; end
      if (ifa.out_tvalid && ifa.out_tready) begin
        if (exp_a.size() == 0) chk("a_extra", {ifa.out_tlast, ifa.out_tdata}, 64'hDEAD_0000_0000);
        else begin
          e = exp_a.pop_front();
          chk("a_sample", {ifa.out_tlast, ifa.out_tdata}, e);
        end
      end
      stall_a = ifa.out_tvalid && !ifa.out_tready;
      hold_a  = {ifa.out_tlast, ifa.out_tdata};
    end
  end

  always @(negedge clk) begin : mon_b
    logic [32:0] e;
    if (!reset) begin
      stall_b = 1'b0;
    end else begin
      if (stall_b) chk("b_hold", {ifb.out_tvalid, ifb.out_tlast, ifb.out_tdata}, {1'b1, hold_b});
      if (ifb.out_tvalid && ifb.out_tready) begin
        if (exp_b.size() == 0) chk("b_extra", {ifb.out_tlast, ifb.out_tdata}, 64'hDEAD_0000_0000);
        else begin
          e = exp_b.pop_front();
          chk("b_sample", {ifb.out_tlast, 8'h00, ifb.out_tdata}, e);
        end
      end
      stall_b = ifb.out_tvalid && !ifb.out_tready;
      hold_b  = {ifb.out_tlast, ifb.out_tdata};
    end
  end

  initial begin
    ifa.in_tdata = '0; ifa.in_tvalid = 1'b0; ifa.in_tlast = 1'b0; ifa.out_tready = 1'b0;
    ifb.in_tdata = '0; ifb.in_tvalid = 1'b0; ifb.in_tlast = 1'b0; ifb.out_tready = 1'b0;
    cnt_m = '{0, 0};
    len_m = '{1, 1};
    repeat (3) @(negedge clk);
    chk("rst_a_valid", {ifa.out_tvalid, ifa.out_tlast, ifa.in_tready}, 64'd0);
    chk("rst_a_data", ifa.out_tdata, 64'd0);
    chk("rst_a_level", level_a, 64'd0);
    chk("rst_b_flags", {ifb.out_tvalid, ifb.in_tready, ovf_b}, 64'd0);
    chk("rst_b_drops", drop_b, 64'd0);
    reset = 1'b1;
    lat_arm = 1'b1;

    // Two beats, 4-sample packet; first valid two clocks after accept.
    send(0, 64'h0003_0004_0001_0002, 1'b0, 1'b1);
    chk("accept_cycle_recorded", 64'(acc_cyc > 0), 64'd1);
    begin : lat_capture
      int a0;
      a0 = acc_cyc;
      send(0, 64'h0007_0008_0005_0006, 1'b0, 1'b1);
      idle();
      drain();
      chk("latency", 64'(first_v - a0), 64'd2);
    end

    // Narrowing with rounding/saturation, then spaced random beats.
    send(1, 64'h8000_FFF7_7FF8_0018, 1'b0, 1'b1);
    idle();
    repeat (5) @(negedge clk);
    send(1, 64'h0008_FFF8_8010_7FF7, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 10; i++) begin
      repeat (4 + $urandom_range(0, 2)) @(negedge clk);
      send(1, {$urandom(), $urandom()}, ($urandom_range(0, 7) == 0), 1'b1);
      idle();
    end
    drain();

    // Backpressure: stalled output fills the FIFO, nothing is lost.
    rdy_a = 0;
    fork
      for (int i = 0; i < 6; i++) send(0, {$urandom(), $urandom()}, 1'b0, 1'b1);
      begin
        repeat (15) @(negedge clk);
        chk("bp_ready_low", ifa.in_tready, 64'd0);
        chk("bp_level_full", level_a, 64'd4);
        rdy_a = 1;
      end
    join
    idle();
    drain();
    chk("bp_no_overflow", {ovf_a, drop_a}, 64'd0);

    // Drop mode: holding register takes one beat, FIFO four, the rest drop.
    rdy_b = 0;
    send(1, {$urandom(), $urandom()}, 1'b0, 1'b1);
    idle();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) send(1, {$urandom(), $urandom()}, 1'b0, (i < 4));
    idle();
    chk("drop_overflow", ovf_b, 64'd1);
    chk("drop_count", drop_b, 64'd3);
    chk("drop_level", level_b, 64'd4);
    rdy_b = 1;
    drain();

    // Random traffic with random output stalls.
    rdy_a = 2;
    for (int i = 0; i < 12; i++) begin
      send(0, {$urandom(), $urandom()}, ($urandom_range(0, 4) == 0), 1'b1);
      if ($urandom_range(0, 2) == 0) begin idle(); repeat ($urandom_range(0, 3)) @(negedge clk); end
    end
    idle();
    drain();

    // Reset mid-packet with beats buffered.
    rdy_a = 0;
    send(0, {$urandom(), $urandom()}, 1'b0, 1'b1);
    send(0, {$urandom(), $urandom()}, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", ifa.out_tvalid, 64'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_out", {ifa.out_tvalid, ifa.out_tlast, ifa.out_tdata}, 64'd0);
    chk("mid_rst_level", {level_a, ifa.in_tready}, 64'd0);
    chk("mid_rst_b", {ovf_b, drop_b}, 64'd0);
    exp_a.delete();
    exp_b.delete();
    cnt_m = '{0, 0};
    cfg_a = 12'd100;
    cfg_b = 12'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // in_tlast on 3rd beat ends a 100-sample packet at sample 6.
    rdy_a = 2;
    send(0, {$urandom(), $urandom()}, 1'b0, 1'b1);
    send(0, {$urandom(), $urandom()}, 1'b0, 1'b1);
    send(0, {$urandom(), $urandom()}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(0, {$urandom(), $urandom()}, 1'b0, 1'b1);
    send(0, {$urandom(), $urandom()}, 1'b1, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      send(1, {$urandom(), $urandom()}, 1'b0, 1'b1);
      idle();
      repeat (5) @(negedge clk);
    end
    drain();

    // Short packets that straddle beats.
    cfg_a = 12'd3;
    for (int i = 0; i < 15; i++) begin
      send(0, {$urandom(), $urandom()}, ($urandom_range(0, 5) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
